// File: rtl/pattern_det_prog.sv
// -----------------------------------------------------------------------------
// pattern_det_prog
//
// Programmable serial pattern detector. A pattern of 1..PAT_W bits is loaded
// at run time and then matched against a serial bit stream, in overlapping or
// non-overlapping mode. A one-cycle pulse is raised on `pattern` the cycle
// after the bit that completes a match is sampled.
//
// Parameters
//   PAT_W  maximum pattern length in bits (2..32)
//   CNT_W  match counter width
//   LEN_W  width of cfg_len, must equal $clog2(PAT_W)+1
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset, overrides everything else
//   cfg_load   one-cycle strobe capturing cfg_pat / cfg_len / cfg_ovl
//   cfg_pat    pattern; first serial bit is cfg_pat[len-1], last is cfg_pat[0]
//   cfg_len    pattern length (0 loads as 1, >PAT_W loads as PAT_W)
//   cfg_ovl    1 = overlapping detection, 0 = non-overlapping
//   d_i        serial data bit
//   valid_i    d_i qualifier
//   pattern    registered one-cycle match pulse
//   match_cnt  saturating match count (only with PATDET_MATCH_CNT_EN)
//   armed      a configuration is loaded (FSM not idle)
//
// Build option
//   PATDET_MATCH_CNT_EN  when defined, adds the match_cnt port and counter.
// -----------------------------------------------------------------------------
module pattern_det_prog #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             d_i,
    input  logic             valid_i,
    output logic             pattern,
`ifdef PATDET_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             armed
);

    // Elaboration-time guard on the parameter set.
    if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1 || LEN_W != $clog2(PAT_W) + 1) begin : g_param_check
        $error("pattern_det_prog: illegal parameter combination");
    end

    localparam logic [LEN_W-1:0] PatWLen = LEN_W'(PAT_W);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StFill = 2'b01,
        StHunt = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               pattern_q, pattern_d;

    logic [PAT_W-1:0]   hist_shift;
    logic [PAT_W-1:0]   len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic               fill_done;
    logic               consume;
    logic               cmp_hit;
    logic               check;
    logic               match;
    logic               restart;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    always_comb begin
        // Compare against history including the bit arriving this cycle, so the
        // completing bit is matched with no extra cycle of delay.
        hist_shift = {hist_q[PAT_W-2:0], d_i};

        len_mask = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            len_mask[i] = (i < int'(len_q));
        end

        fill_inc  = fill_q + LEN_W'(1);
        fill_done = (fill_inc == len_q);

        // A bit coinciding with cfg_load is discarded.
        consume = valid_i && !cfg_load;

        cmp_hit = (((hist_shift ^ pat_q) & len_mask) == '0);
        check   = consume && ((state_q == StHunt) || ((state_q == StFill) && fill_done));
        match   = check && cmp_hit;

        // Non-overlapping match starts over with fresh bits.
        restart = match && !ovl_q;

        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > PatWLen) begin
            len_clamped = PatWLen;
        end else begin
            len_clamped = cfg_len;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = StFill;
        end else begin
            case (state_q)
                StIdle: state_d = StIdle;
                StFill: begin
                    if (consume && fill_done) begin
                        state_d = restart ? StFill : StHunt;
                    end
                end
                StHunt: begin
                    if (restart) begin
                        state_d = StFill;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        pattern = pattern_q;
        armed   = (state_q != StIdle);
    end

    // -------------------------------------------------------------------------
    // Configuration, history and fill counter
    // -------------------------------------------------------------------------
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = match;

        if (cfg_load) begin
            pat_d  = cfg_pat;
            len_d  = len_clamped;
            ovl_d  = cfg_ovl;
            hist_d = '0;
            fill_d = '0;
        end else if (consume && (state_q != StIdle)) begin
            if (restart) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_shift;
                // In HUNT the counter already equals len and stays there.
                if (state_q == StFill) begin
                    fill_d = fill_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= '0;
            len_q     <= LEN_W'(1);
            ovl_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
        end
    end

`ifdef PATDET_MATCH_CNT_EN
    // -------------------------------------------------------------------------
    // Saturating match counter, advanced together with the pulse register so
    // the count and the pulse become visible in the same cycle.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pattern_det_prog.sv
// -----------------------------------------------------------------------------
// tb_pattern_det_prog
//
// Directed self-checking bench for pattern_det_prog. Bits are driven on the
// falling edge and outputs sampled 1 time unit after the rising edge, so the
// observed `pattern` corresponds to the bit just sampled. Counter checks are
// compiled in only when PATDET_MATCH_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pattern_det_prog;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned LEN_W = 4;

    logic             clk;
    logic             rst;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             d_i;
    logic             valid_i;
    logic             pattern;
    logic             armed;
`ifdef PATDET_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pattern_det_prog #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_load  (cfg_load),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_ovl   (cfg_ovl),
        .d_i       (d_i),
        .valid_i   (valid_i),
        .pattern   (pattern),
`ifdef PATDET_MATCH_CNT_EN
        .match_cnt (match_cnt),
`endif
        .armed     (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp);
`ifdef PATDET_MATCH_CNT_EN
        check(tag, 32'(match_cnt), exp);
`else
        if (tag.len() == 0 && exp == 32'hFFFF_FFFF) $info("unused");
`endif
    endtask

    // Send n bits MSB-first; exp[i] is the required pulse after bit bits[i].
    task automatic send(input string tag, input logic [15:0] bits, input int n,
                        input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            valid_i = 1'b1;
            d_i     = bits[i];
            @(posedge clk);
            #1;
            check($sformatf("%s bit%0d", tag, n - i), 32'(pattern), 32'(exp[i]));
        end
        @(negedge clk);
        valid_i = 1'b0;
        d_i     = 1'b0;
    endtask

    // Idle cycles with valid_i low; pattern must stay low.
    task automatic gap(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            d_i     = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("%s gap%0d", tag, i), 32'(pattern), 32'd0);
        end
    endtask

    // Load with a coincident valid bit (d_i=0) that must be discarded.
    task automatic load(input string tag, input logic [7:0] p, input logic [3:0] l,
                        input logic o);
        @(negedge clk);
        cfg_load = 1'b1;
        cfg_pat  = p;
        cfg_len  = l;
        cfg_ovl  = o;
        valid_i  = 1'b1;
        d_i      = 1'b0;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        valid_i  = 1'b0;
        cfg_pat  = ~p;
        cfg_len  = 4'd3;
        cfg_ovl  = ~o;
        check({tag, " load pattern"}, 32'(pattern), 32'd0);
        check({tag, " load armed"}, 32'(armed), 32'd1);
    endtask

    // One reset cycle with cfg_load and valid_i also high; reset must win.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst      = 1'b1;
        cfg_load = 1'b1;
        cfg_pat  = 8'h01;
        cfg_len  = 4'd1;
        valid_i  = 1'b1;
        d_i      = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        valid_i  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " reset pattern"}, 32'(pattern), 32'd0);
        check({tag, " reset armed"}, 32'(armed), 32'd0);
        check_cnt({tag, " reset cnt"}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        cfg_load = 1'b0;
        cfg_pat  = '0;
        cfg_len  = '0;
        cfg_ovl  = 1'b0;
        d_i      = 1'b0;
        valid_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("por pattern", 32'(pattern), 32'd0);
        check("por armed", 32'(armed), 32'd0);
        check_cnt("por cnt", 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle ignores data, even a pattern that would match the reset len=1/pat=0.
        send("idle", 16'b000, 3, 16'b000);
        check("idle armed", 32'(armed), 32'd0);

        // Overlapping: 01101 in 0,1,1,0,1,1,0,1 -> pulses after 5th and 8th.
        // Upper cfg_pat bits are set to check they do not take part.
        load("ovl1", 8'hED, 4'd5, 1'b1);
        send("ovl1", 16'b0110_1101, 8, 16'b0000_1001);
        check_cnt("ovl1 cnt", 32'd2);

        // Non-overlapping: single pulse after 5th.
        load("ovl0", 8'h0D, 4'd5, 1'b0);
        send("ovl0", 16'b0110_1101, 8, 16'b0000_1000);
        check_cnt("ovl0 cnt", 32'd1);

        // Overlapping with a 3-cycle valid gap between 6th and 7th bits.
        load("gap", 8'h0D, 4'd5, 1'b1);
        send("gapA", 16'b01_1011, 6, 16'b00_0010);
        gap("gap", 3);
        send("gapB", 16'b01, 2, 16'b01);
        check_cnt("gap cnt", 32'd2);

        // len=0 loads as 1.
        load("len0", 8'h01, 4'd0, 1'b1);
        send("len0", 16'b101, 3, 16'b101);
        check_cnt("len0 cnt", 32'd2);

        // Reset after 4 bits, stream without reload must not detect.
        load("rst", 8'h0D, 4'd5, 1'b1);
        send("rstA", 16'b0110, 4, 16'b0000);
        do_reset("rst");
        send("rstB", 16'b0110_1101, 8, 16'b0000_0000);
        check("rst still unarmed", 32'(armed), 32'd0);
        check_cnt("rst cnt", 32'd0);
        load("rel", 8'h0D, 4'd5, 1'b1);
        send("rel", 16'b0110_1101, 8, 16'b0000_1001);

        // Counter saturation: five matches with a 2-bit counter.
        load("sat", 8'h01, 4'd1, 1'b1);
        send("sat", 16'b11111, 5, 16'b11111);
        check_cnt("sat cnt", 32'd3);
        gap("sat", 1);
        check_cnt("sat hold", 32'd3);

        // len above PAT_W loads as PAT_W: only the 8th bit completes a match.
        load("clamp", 8'hA5, 4'd15, 1'b1);
        send("clamp", 16'b1010_0101, 8, 16'b0000_0001);
        check_cnt("clamp cnt", 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_det_prog.md
PATTERN_DET_PROG -- requirements
Module: pattern_det_prog

Interface
REQ-001 SHALL have parameter PAT_W, default 8, meaning maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 16, meaning match counter width.
REQ-003 SHALL have parameter LEN_W, default 4, meaning cfg_len width; its value SHALL be $clog2(PAT_W)+1.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cfg_load  input  1  one-cycle strobe; captures cfg_pat, cfg_len and cfg_ovl.
REQ-007 cfg_pat  input  PAT_W  pattern; the first bit received maps to cfg_pat[len-1] and the last bit to cfg_pat[0].
REQ-008 cfg_len  input  LEN_W  pattern length in bits.
REQ-009 cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 d_i  input  1  serial data bit.
REQ-011 valid_i  input  1  d_i qualifier; bits are consumed only when valid_i=1.
REQ-012 pattern  output  1  registered one-cycle match pulse.
REQ-013 armed  output  1  high when a configuration is loaded (state not IDLE).
REQ-014 match_cnt  output  CNT_W  saturating match count (present only under PATDET_MATCH_CNT_EN).

Function
REQ-015 SHALL implement the FSM states IDLE, FILL and HUNT, encoded in 2 bits.
REQ-016 IDLE: SHALL ignore d_i and valid_i; cfg_load SHALL move the FSM to FILL.
REQ-017 FILL: each valid bit SHALL shift into the history register and increment fill_cnt; when fill_cnt reaches len, the FSM SHALL move to HUNT.
REQ-018 HUNT: each valid bit SHALL shift into history, and the low len bits of history SHALL be compared with the low len bits of the pattern.
REQ-019 The comparison SHALL include the bit arriving in the current cycle, so a match on the len-th bit is detected without an extra cycle of delay.
REQ-020 On a match, pattern SHALL be 1 in the cycle after the completing valid bit is sampled; fixed latency is 1 clk.
REQ-021 On a match with ovl=1, the FSM SHALL stay in HUNT and history SHALL be retained, so that suffix/prefix overlap is detected.
REQ-022 On a match with ovl=0, history and fill_cnt SHALL be cleared and the FSM SHALL go to FILL; the next match SHALL require len fresh bits.
REQ-023 When valid_i=0, history, fill_cnt and state SHALL be held, and pattern SHALL be 0 in the next cycle.
REQ-024 pattern SHALL be 0 in every cycle that does not immediately follow a matching valid bit; it never stretches.
REQ-025 cfg_len=0 SHALL be loaded as 1; cfg_len>PAT_W SHALL be loaded as PAT_W.
REQ-026 cfg_load in any state SHALL overwrite the configuration, clear history and fill_cnt, and go to FILL.
REQ-027 If cfg_load coincides with valid_i, the data bit SHALL be discarded and pattern SHALL be 0 in the next cycle.
REQ-028 history SHALL be PAT_W bits wide; bits above len SHALL be don't-care for the comparison.

Reset
REQ-029 rst=1 SHALL force state IDLE, pattern=0, armed=0, history=0, fill_cnt=0, pat=0, len=1, ovl=0 and match_cnt=0.
REQ-030 rst SHALL take priority over cfg_load and valid_i.
REQ-031 rst mid-stream SHALL discard partial history, and a new cfg_load SHALL be required before any further detection.

Configuration
REQ-032 Macro PATDET_MATCH_CNT_EN defined: match_cnt SHALL increment by 1 on each pattern pulse, saturate at all-ones, and clear on rst or cfg_load.
REQ-033 Macro PATDET_MATCH_CNT_EN undefined: the match_cnt port and its counter logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-034 Load pat=5'b01101, len=5, ovl=1; send valid bits 0,1,1,0,1,1,0,1 -> pattern pulses after the 5th and 8th bits; match_cnt=2.
REQ-035 Same stream with ovl=0 -> a single pulse after the 5th bit; match_cnt=1.
REQ-036 Same as REQ-034 with valid_i=0 for 3 cycles between the 6th and 7th bits -> pulses after the 5th and 8th valid bits only; no pulse during the gaps.
REQ-037 Load len=0, pat=1 and send 1,0,1 -> length clamped to 1; pulses after the 1st and 3rd bits.
REQ-038 Assert rst after bit 4 of the REQ-034 stream, then reload and resend the full stream -> no pulse before the 5th post-reload bit; armed=0 from reset until cfg_load.
REQ-039 Counter saturation with CNT_W=2 under PATDET_MATCH_CNT_EN, using 5 matches -> match_cnt reads 3 and holds at 3.
